// File: rtl/bsg_fpu_div_pkg.sv
// rtl/bsg_fpu_div_pkg.sv - shared types for the iterative floating-point divider
//
// Purpose: sequencing states used by bsg_fpu_div.
//   IDLE  : waiting for operands (ready_o high when enabled)
//   CALC  : restoring mantissa division, one quotient bit per enabled cycle
//   ROUND : normalise, round-to-nearest-even, select special/arith result
//   DONE  : result presented until the consumer takes it
package bsg_fpu_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/bsg_fpu_div_mant_iter.sv
// rtl/bsg_fpu_div_mant_iter.sv - restoring mantissa divider datapath
//
// Purpose: holds remainder, divisor, quotient and iteration counter for a
// restoring division of {1,man_a} by {1,man_b}. One quotient bit per step.
// Ports:
//   clk_i, reset_i  clock, synchronous active-high reset
//   load_i          load operands, clear quotient and counter
//   step_i          perform one restoring iteration
//   man_a_i/man_b_i dividend/divisor mantissas (hidden bit implied)
//   done_o          the current step is the final (m_p+3)th iteration
//   quot_o          quotient bits, MSB first
//   rem_nz_o        remainder is non-zero (sticky contribution)
module bsg_fpu_div_mant_iter #(
  parameter int m_p = 23
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           load_i,
  input  logic           step_i,
  input  logic [m_p-1:0] man_a_i,
  input  logic [m_p-1:0] man_b_i,
  output logic           done_o,
  output logic [m_p+2:0] quot_o,
  output logic           rem_nz_o
);

  localparam int cnt_w_lp = $clog2(m_p + 3);

  logic [m_p+1:0]    rem_q, rem_d, div_q, diff;
  logic [m_p+2:0]    quot_q, quot_d;
  logic [cnt_w_lp-1:0] cnt_q;
  logic              q_bit;

  // Remainder stays below twice the divisor, so after a conditional subtract
  // the top bit is always clear and the left shift cannot lose information.
  always_comb begin
    q_bit  = (rem_q >= div_q);
    diff   = q_bit ? (rem_q - div_q) : rem_q;
    rem_d  = {diff[m_p:0], 1'b0};
    quot_d = {quot_q[m_p+1:0], q_bit};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rem_q  <= '0;
      div_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      rem_q  <= {2'b01, man_a_i};
      div_q  <= {2'b01, man_b_i};
      quot_q <= '0;
      cnt_q  <= '0;
    end else if (step_i) begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      cnt_q  <= cnt_q + cnt_w_lp'(1);
    end
  end

  assign done_o   = (cnt_q == cnt_w_lp'(m_p + 2));
  assign quot_o   = quot_q;
  assign rem_nz_o = |rem_q;

endmodule

// File: rtl/bsg_fpu_preprocess.sv
// rtl/bsg_fpu_preprocess.sv - IEEE-754 operand classification
//
// Purpose: split an operand into fields and classify it.
// Ports:
//   a_i        operand {sign, exponent, mantissa}
//   zero_o     +/- zero
//   nan_o      any NaN (quiet or signalling)
//   sig_nan_o  signalling NaN (mantissa MSB clear)
//   infty_o    +/- infinity
//   denormal_o non-zero operand with zero exponent
//   sign_o     sign bit
//   exp_o      biased exponent field
//   man_o      mantissa field (hidden bit not included)
module bsg_fpu_preprocess #(
  parameter int e_p = 8,
  parameter int m_p = 23
) (
  input  logic [e_p+m_p:0] a_i,
  output logic             zero_o,
  output logic             nan_o,
  output logic             sig_nan_o,
  output logic             infty_o,
  output logic             denormal_o,
  output logic             sign_o,
  output logic [e_p-1:0]   exp_o,
  output logic [m_p-1:0]   man_o
);

  logic exp_zero;
  logic exp_ones;
  logic man_zero;

  assign sign_o   = a_i[e_p+m_p];
  assign exp_o    = a_i[e_p+m_p-1:m_p];
  assign man_o    = a_i[m_p-1:0];

  assign exp_zero = ~|exp_o;
  assign exp_ones = &exp_o;
  assign man_zero = ~|man_o;

  assign zero_o     = exp_zero & man_zero;
  assign denormal_o = exp_zero & ~man_zero;
  assign infty_o    = exp_ones & man_zero;
  assign nan_o      = exp_ones & ~man_zero;
  assign sig_nan_o  = nan_o & ~man_o[m_p-1];

endmodule

// File: rtl/bsg_fpu_div.sv
// rtl/bsg_fpu_div.sv - iterative IEEE-754 divider z = a / b
//
// Purpose: fixed-latency restoring divider, round-to-nearest-even, denormal
// results flushed to zero, denormal operands reported as unimplemented.
// Ports:
//   clk_i, reset_i    clock, synchronous active-high reset
//   en_i              global enable; low freezes all state
//   v_i, a_i, b_i     operand valid, dividend, divisor
//   ready_o           accepting operands
//   v_o, z_o          result valid, quotient
//   unimplemented_o, invalid_o, overflow_o, underflow_o, divide_by_zero_o
//                     exception flags, valid with v_o
//   yumi_i            consumer takes the result
module bsg_fpu_div
  import bsg_fpu_div_pkg::*;
#(
  parameter int e_p = 8,
  parameter int m_p = 23
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic             v_i,
  input  logic [e_p+m_p:0] a_i,
  input  logic [e_p+m_p:0] b_i,
  output logic             ready_o,
  output logic             v_o,
  output logic [e_p+m_p:0] z_o,
  output logic             unimplemented_o,
  output logic             invalid_o,
  output logic             overflow_o,
  output logic             underflow_o,
  output logic             divide_by_zero_o,
  input  logic             yumi_i
);

  localparam int w_lp = e_p + m_p + 1;
  localparam logic [w_lp-1:0] quiet_nan_lp = {1'b0, {e_p{1'b1}}, 1'b1, {(m_p-1){1'b0}}};
  localparam logic [w_lp-1:0] sig_nan_lp   = {1'b0, {e_p{1'b1}}, 2'b01, {(m_p-2){1'b0}}};
  localparam logic signed [e_p+1:0] bias_lp = (e_p+2)'((1 << (e_p-1)) - 1);
  localparam logic signed [e_p+1:0] emax_lp = (e_p+2)'((1 << e_p) - 1);

  state_e state_q, state_d;
  logic   load, step, iter_done, rem_nz;
  logic [m_p+2:0] quot;

  logic a_zero, a_nan, a_sn, a_inf, a_den, a_sign;
  logic b_zero, b_nan, b_sn, b_inf, b_den, b_sign;
  logic [e_p-1:0] a_exp, b_exp;
  logic [m_p-1:0] a_man, b_man;

  bsg_fpu_preprocess #(.e_p(e_p), .m_p(m_p)) a_pp (
    .a_i(a_i), .zero_o(a_zero), .nan_o(a_nan), .sig_nan_o(a_sn), .infty_o(a_inf),
    .denormal_o(a_den), .sign_o(a_sign), .exp_o(a_exp), .man_o(a_man));

  bsg_fpu_preprocess #(.e_p(e_p), .m_p(m_p)) b_pp (
    .a_i(b_i), .zero_o(b_zero), .nan_o(b_nan), .sig_nan_o(b_sn), .infty_o(b_inf),
    .denormal_o(b_den), .sign_o(b_sign), .exp_o(b_exp), .man_o(b_man));

  bsg_fpu_div_mant_iter #(.m_p(m_p)) iter (
    .clk_i(clk_i), .reset_i(reset_i), .load_i(load), .step_i(step),
    .man_a_i(a_man), .man_b_i(b_man), .done_o(iter_done), .quot_o(quot),
    .rem_nz_o(rem_nz));

  // Special cases are resolved at accept time and carried alongside the
  // mantissa iteration so latency does not depend on the operands.
  logic            sign_x, sp_v, sp_inv, sp_dbz, sp_unimp;
  logic [w_lp-1:0] sp_z;
  logic signed [e_p+1:0] exp_diff_d;

  always_comb begin
    sign_x   = a_sign ^ b_sign;
    sp_v     = 1'b1;
    sp_z     = '0;
    sp_inv   = 1'b0;
    sp_dbz   = 1'b0;
    sp_unimp = 1'b0;
    if (a_sn | b_sn) begin
      sp_z = sig_nan_lp; sp_inv = 1'b1;
    end else if (a_nan | b_nan) begin
      sp_z = quiet_nan_lp;
    end else if ((a_inf & b_inf) | (a_zero & b_zero)) begin
      sp_z = quiet_nan_lp; sp_inv = 1'b1;
    end else if (a_inf) begin
      sp_z = {sign_x, {e_p{1'b1}}, {m_p{1'b0}}};
    end else if (b_inf) begin
      sp_z = {sign_x, {(w_lp-1){1'b0}}};
    end else if (b_zero) begin
      sp_z = {sign_x, {e_p{1'b1}}, {m_p{1'b0}}}; sp_dbz = 1'b1;
    end else if (a_zero) begin
      sp_z = {sign_x, {(w_lp-1){1'b0}}};
    end else if (a_den | b_den) begin
      sp_z = quiet_nan_lp; sp_unimp = 1'b1;
    end else begin
      sp_v = 1'b0;
    end
    exp_diff_d = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + bias_lp;
  end

  logic            sign_q, sp_v_q, sp_inv_q, sp_dbz_q, sp_unimp_q;
  logic [w_lp-1:0] sp_z_q;
  logic signed [e_p+1:0] exp_diff_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sign_q <= 1'b0; sp_v_q <= 1'b0; sp_z_q <= '0;
      sp_inv_q <= 1'b0; sp_dbz_q <= 1'b0; sp_unimp_q <= 1'b0;
      exp_diff_q <= '0;
    end else if (load) begin
      sign_q <= sign_x; sp_v_q <= sp_v; sp_z_q <= sp_z;
      sp_inv_q <= sp_inv; sp_dbz_q <= sp_dbz; sp_unimp_q <= sp_unimp;
      exp_diff_q <= exp_diff_d;
    end
  end

  // Normalise: a quotient of [1,2) has its MSB set, [0.5,1) needs one shift.
  logic [m_p-1:0] mant;
  logic [m_p:0]   mant_r;
  logic           guard, sticky, round_up;
  logic signed [e_p+1:0] e_pre, e_r;
  logic [w_lp-1:0] z_d;
  logic            ovf_d, unf_d;

  always_comb begin
    if (quot[m_p+2]) begin
      mant   = quot[m_p+1:2];
      guard  = quot[1];
      sticky = quot[0] | rem_nz;
      e_pre  = exp_diff_q;
    end else begin
      mant   = quot[m_p:1];
      guard  = quot[0];
      sticky = rem_nz;
      e_pre  = exp_diff_q - (e_p+2)'(1);
    end
    round_up = guard & (sticky | mant[0]);
    mant_r   = {1'b0, mant} + (m_p+1)'(round_up);
    e_r      = e_pre + $signed({{(e_p+1){1'b0}}, mant_r[m_p]});
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    if (e_r[e_p+1] || (e_r == '0)) begin
      z_d   = {sign_q, {(w_lp-1){1'b0}}};
      unf_d = 1'b1;
    end else if (e_r >= emax_lp) begin
      z_d   = {sign_q, {e_p{1'b1}}, {m_p{1'b0}}};
      ovf_d = 1'b1;
    end else begin
      z_d   = {sign_q, e_r[e_p-1:0], mant_r[m_p-1:0]};
    end
    if (sp_v_q) begin
      z_d   = sp_z_q;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      z_o <= '0; unimplemented_o <= 1'b0; invalid_o <= 1'b0;
      overflow_o <= 1'b0; underflow_o <= 1'b0; divide_by_zero_o <= 1'b0;
    end else if (en_i && (state_q == ROUND)) begin
      z_o <= z_d;
      unimplemented_o  <= sp_v_q & sp_unimp_q;
      invalid_o        <= sp_v_q & sp_inv_q;
      divide_by_zero_o <= sp_v_q & sp_dbz_q;
      overflow_o       <= ovf_d;
      underflow_o      <= unf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    if (en_i) begin
      case (state_q)
        IDLE:  if (v_i) begin load = 1'b1; state_d = CALC; end
        CALC:  begin step = 1'b1; if (iter_done) state_d = ROUND; end
        ROUND: state_d = DONE;
        DONE:  if (yumi_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign ready_o = en_i & ~reset_i & (state_q == IDLE);
  assign v_o     = ~reset_i & (state_q == DONE);

endmodule

// File: tb/tb_bsg_fpu_div.sv
// tb/tb_bsg_fpu_div.sv - self-checking bench for bsg_fpu_div
module tb_bsg_fpu_div;

  localparam int E = 8;
  localparam int M = 23;
  localparam int NOM_LAT = 27;

  logic        clk = 1'b0;
  logic        reset_i, en_i, v_i, yumi_i;
  logic [31:0] a_i, b_i, z_o;
  logic        ready_o, v_o;
  logic        unimplemented_o, invalid_o, overflow_o, underflow_o, divide_by_zero_o;
  logic [4:0]  flags;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [36:0] sb_q[$];

  always #5 clk = ~clk;

  bsg_fpu_div #(.e_p(E), .m_p(M)) dut (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .v_i(v_i), .a_i(a_i), .b_i(b_i),
    .ready_o(ready_o), .v_o(v_o), .z_o(z_o), .unimplemented_o(unimplemented_o),
    .invalid_o(invalid_o), .overflow_o(overflow_o), .underflow_o(underflow_o),
    .divide_by_zero_o(divide_by_zero_o), .yumi_i(yumi_i));

  // flag order: {unimplemented, invalid, overflow, underflow, divide_by_zero}
  assign flags = {unimplemented_o, invalid_o, overflow_o, underflow_o, divide_by_zero_o};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] z_exp, input logic [4:0] f_exp,
                       input int pause_at, input int pause_len, input int hold);
    int          edges;
    logic [36:0] ex;
    sb_q.push_back({z_exp, f_exp});
    edges = 0;
    while (!ready_o && edges < 50) begin tick(); edges++; end
    check({tag, " ready"}, 64'(ready_o), 64'd1);
    a_i = a; b_i = b; v_i = 1'b1;
    tick();
    v_i = 1'b0;
    edges = 0;
    while (!v_o && edges < 200) begin
      en_i = !(pause_len > 0 && edges >= pause_at && edges < pause_at + pause_len);
      tick();
      edges++;
    end
    en_i = 1'b1;
    check({tag, " latency"}, 64'(edges), 64'(NOM_LAT + pause_len));
    ex = sb_q.pop_front();
    check({tag, " z"}, 64'(z_o), 64'(ex[36:5]));
    check({tag, " flags"}, 64'(flags), 64'(ex[4:0]));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, " hold"}, {25'd0, v_o, ready_o, z_o, flags}, {25'd0, 1'b1, 1'b0, ex});
    end
    yumi_i = 1'b1;
    tick();
    yumi_i = 1'b0;
    check({tag, " release"}, {62'd0, v_o, ready_o}, 64'b01);
  endtask

  initial begin : stim
    int   edges;
    logic seen_v;
    reset_i = 1'b1; en_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0;
    a_i = '0; b_i = '0;
    #1;
    check("ready in reset", 64'(ready_o), 64'd0);
    tick(); tick();
    check("reset outputs", {26'd0, v_o, z_o, flags}, 64'd0);
    reset_i = 1'b0;
    #1;
    check("ready after reset", 64'(ready_o), 64'd1);

    do_op("6/2",       32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 0, 0, 5);
    do_op("1/3",       32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00000, 0, 0, 0);
    do_op("3/1",       32'h40400000, 32'h3F800000, 32'h40400000, 5'b00000, 0, 0, 0);
    do_op("-6/2",      32'hC0C00000, 32'h40000000, 32'hC0400000, 5'b00000, 0, 0, 0);
    do_op("1/0",       32'h3F800000, 32'h00000000, 32'h7F800000, 5'b00001, 0, 0, 0);
    do_op("0/0",       32'h00000000, 32'h00000000, 32'h7FC00000, 5'b01000, 0, 0, 0);
    do_op("snan/1",    32'h7F800001, 32'h3F800000, 32'h7FA00000, 5'b01000, 0, 0, 0);
    do_op("overflow",  32'h7F000000, 32'h3E800000, 32'h7F800000, 5'b00100, 0, 0, 0);
    do_op("underflow", 32'h00800000, 32'h40000000, 32'h00000000, 5'b00010, 0, 0, 0);
    do_op("denormal",  32'h00000001, 32'h3F800000, 32'h7FC00000, 5'b10000, 0, 0, 0);
    do_op("en pause",  32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 6, 3, 0);

    // abort mid-CALC with a one-cycle reset
    a_i = 32'h3F800000; b_i = 32'h40400000; v_i = 1'b1;
    tick();
    v_i = 1'b0;
    repeat (5) tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    #1;
    check("abort v_o", 64'(v_o), 64'd0);
    check("abort ready", 64'(ready_o), 64'd1);
    seen_v = 1'b0;
    edges = 0;
    while (edges < 35) begin tick(); seen_v |= v_o; edges++; end
    check("abort no stale", 64'(seen_v), 64'd0);

    do_op("post-abort", 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
